link_rx_deframer: RTL and testbench

//  Receive end of the off-chip 16-bit link. Collects four 16-bit beats into one 64-bit word,

---
 rtl/link_pkg.sv | 21 ++
 rtl/link_rx_fifo.sv | 55 +++++
 rtl/link_rx_deframer.sv | 115 +++++++++++
 tb/tb_link_rx_deframer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared link definitions: beat/word geometry, receive assembly states and the lane interleave map.
package link_pkg;

   localparam int unsigned BEAT_W         = 16;
   localparam int unsigned WORD_W         = 64;
   localparam int unsigned BEATS_PER_WORD = 4;

   typedef enum logic [1:0] {IDLE, B1, B2, B3} asm_state_e;

   // Beat k carries byte k in its low half and byte k+4 in its high half.
   function automatic logic [WORD_W-1:0] lane_place(input logic [WORD_W-1:0] word,
                                                    input logic [BEAT_W-1:0] beat,
                                                    input logic [1:0]        idx);
      logic [WORD_W-1:0] w;
      w                       = word;
      w[8*32'(idx) +: 8]      = beat[7:0];
      w[8*(32'(idx)+4) +: 8]  = beat[15:8];
      return w;
   endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Word FIFO for the link receiver: DEPTH x 64, occupancy count, head read straight from storage.
module link_rx_fifo
   import link_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [WORD_W-1:0] i_data,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_empty,
   output logic [WORD_W-1:0] o_head,
   output logic [CNT_W-1:0]  o_count
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push_ok;
   logic              w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_pop_ok  = i_pop && !o_empty;
   // A simultaneous pop frees the slot being written, so a full FIFO still takes the push.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
      end
   end

endmodule

// File: rtl/link_rx_deframer.sv
// Link receive deframer: four interleaved beats -> 64-bit word -> FIFO -> valid/ready, with credits.
// Define LINK_PARITY_EN to check per-beat even parity and drop words containing a bad beat.
module link_rx_deframer
   import link_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_valid,
   input  logic              beat_sof,
   input  logic [BEAT_W-1:0] beat_data,
   input  logic              beat_par,
   output logic [WORD_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready,
   output logic              credit_ret,
   output logic [CNT_W-1:0]  count,
   output logic              err_framing,
   output logic              err_overflow,
   output logic              err_parity
);

   asm_state_e        r_state;
   logic [WORD_W-1:0] r_asm;
   logic              r_par_bad;
   logic              r_credit;
   logic              r_err_framing;
   logic              r_err_overflow;
   logic              r_err_parity;

   logic [1:0]        w_idx;
   logic [WORD_W-1:0] w_word;
   logic              w_par_bad;
   logic              w_accept;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;

`ifdef LINK_PARITY_EN
   assign w_par_bad = beat_valid && ((^beat_data) != beat_par);
`else
   logic w_unused_par;
   assign w_unused_par = beat_par;
   assign w_par_bad    = 1'b0;
`endif

   assign w_idx    = r_state;
   assign w_word   = lane_place(r_asm, beat_data, w_idx);
   assign w_accept = beat_valid && (beat_sof || (r_state != IDLE));
   assign w_last   = beat_valid && !beat_sof && (32'(w_idx) == BEATS_PER_WORD - 1);
   assign w_push   = w_last && !(r_par_bad || w_par_bad);
   assign w_pop    = valid_out && ready;

   link_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (data_out),
      .o_count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_asm          <= '0;
         r_par_bad      <= 1'b0;
         r_credit       <= 1'b0;
         r_err_framing  <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_parity   <= 1'b0;
      end else begin
         r_credit <= w_pop;
         if (w_push && w_full && !w_pop) r_err_overflow <= 1'b1;
         if (w_accept && w_par_bad)      r_err_parity   <= 1'b1;
         if (beat_valid) begin
            if (beat_sof) begin
               // sof always restarts the word; mid-word it is also a framing error.
               if (r_state != IDLE) r_err_framing <= 1'b1;
               r_asm     <= lane_place(r_asm, beat_data, 2'd0);
               r_par_bad <= w_par_bad;
               r_state   <= B1;
            end else begin
               unique case (r_state)
                  IDLE:    r_err_framing <= 1'b1;
                  B1:      r_state <= B2;
                  B2:      r_state <= B3;
                  B3:      r_state <= IDLE;
                  default: r_state <= IDLE;
               endcase
               if (r_state != IDLE) begin
                  r_asm     <= w_word;
                  r_par_bad <= r_par_bad || w_par_bad;
               end
            end
         end
      end
   end

   assign valid_out    = !w_empty;
   assign credit_ret   = r_credit;
   assign err_framing  = r_err_framing;
   assign err_overflow = r_err_overflow;
   assign err_parity   = r_err_parity;

endmodule

// File: tb/tb_link_rx_deframer.sv
// Self-checking bench for link_rx_deframer: directed scenarios plus random beat streams vs a
// byte-level queue model. The parity scenario runs only when LINK_PARITY_EN is defined.
module tb_link_rx_deframer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        beat_valid;
   logic        beat_sof;
   logic [15:0] beat_data;
   logic        beat_par;
   logic [63:0] data_out;
   logic        valid_out;
   logic        ready;
   logic        credit_ret;
   logic [2:0]  count;
   logic        err_framing;
   logic        err_overflow;
   logic        err_parity;

   int checks = 0;
   int errors = 0;

   // Reference model: bytes gathered so far, words queued, sticky flags, expected credit.
   int          m_n;
   logic [7:0]  m_bytes [8];
   bit          m_bad;
   logic [63:0] m_q [$];
   bit          m_ef, m_eo, m_ep, m_cr;

   link_rx_deframer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .beat_valid   (beat_valid),
      .beat_sof     (beat_sof),
      .beat_data    (beat_data),
      .beat_par     (beat_par),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .ready        (ready),
      .credit_ret   (credit_ret),
      .count        (count),
      .err_framing  (err_framing),
      .err_overflow (err_overflow),
      .err_parity   (err_parity)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit par_bad(input logic [15:0] d, input bit p);
`ifdef LINK_PARITY_EN
      return (^d) != p;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      m_n   = 0;
      m_bad = 1'b0;
      m_q.delete();
      m_ef  = 1'b0;
      m_eo  = 1'b0;
      m_ep  = 1'b0;
      m_cr  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":valid"}, 64'(valid_out), 64'(m_q.size() != 0));
      chk({tag, ":count"}, 64'(count), 64'(m_q.size()));
      if (m_q.size() != 0) chk({tag, ":data"}, data_out, m_q[0]);
      chk({tag, ":credit"}, 64'(credit_ret), 64'(m_cr));
      chk({tag, ":err_framing"}, 64'(err_framing), 64'(m_ef));
      chk({tag, ":err_overflow"}, 64'(err_overflow), 64'(m_eo));
      chk({tag, ":err_parity"}, 64'(err_parity), 64'(m_ep));
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic cycle(input bit v, input bit s, input logic [15:0] d, input bit p,
                        input bit rdy, input string tag);
      bit          pop;
      bit          done;
      bit          bad;
      logic [63:0] w;
      beat_valid = v;
      beat_sof   = s;
      beat_data  = d;
      beat_par   = p;
      ready      = rdy;
      pop        = (m_q.size() != 0) && rdy;
      done       = 1'b0;
      bad        = par_bad(d, p);
      if (v) begin
         if (s) begin
            if (m_n != 0) m_ef = 1'b1;
            if (bad) m_ep = 1'b1;
            m_bytes[0] = d[7:0];
            m_bytes[4] = d[15:8];
            m_bad      = bad;
            m_n        = 1;
         end else if (m_n == 0) begin
            m_ef = 1'b1;
         end else begin
            if (bad) m_ep = 1'b1;
            m_bytes[m_n]     = d[7:0];
            m_bytes[m_n + 4] = d[15:8];
            m_bad            = m_bad || bad;
            m_n++;
            if (m_n == 4) begin
               done = 1'b1;
               m_n  = 0;
            end
         end
      end
      if (pop) void'(m_q.pop_front());
      m_cr = pop;
      if (done && !m_bad) begin
         for (int b = 0; b < 8; b++) w[8*b +: 8] = m_bytes[b];
         if (m_q.size() < DEPTH) m_q.push_back(w);
         else                    m_eo = 1'b1;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst        = 1'b1;
      beat_valid = 1'b0;
      beat_sof   = 1'b0;
      beat_data  = '0;
      beat_par   = 1'b0;
      ready      = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_all(tag);
      chk({tag, ":data_zero"}, data_out, 64'h0);
   endtask

   function automatic logic [15:0] beat_of(input logic [63:0] w, input int k);
      return {w[8*(k+4) +: 8], w[8*k +: 8]};
   endfunction

   task automatic send_word(input logic [63:0] w, input bit rdy, input bit rdy_last,
                            input int bad_k, input string tag);
      logic [15:0] d;
      for (int k = 0; k < 4; k++) begin
         d = beat_of(w, k);
         cycle(1'b1, k == 0, d, (^d) ^ (k == bad_k), (k == 3) ? rdy_last : rdy, tag);
      end
   endtask

   task automatic idle(input int n, input bit rdy, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom), 1'b0, rdy, tag);
   endtask

   initial begin
      logic [63:0] w;
      logic [15:0] d;
      int          pulses;
      int          pos;
      bit          v;
      bit          s;

      // Basic assembly, latency and credit pulse.
      do_reset("t1_reset");
      send_word(64'h0706050403020100, 1'b1, 1'b1, -1, "t1");
      chk("t1_valid", 64'(valid_out), 64'h1);
      chk("t1_word", data_out, 64'h0706050403020100);
      idle(1, 1'b1, "t1_pop");
      chk("t1_credit", 64'(credit_ret), 64'h1);
      idle(1, 1'b1, "t1_after");
      chk("t1_credit_off", 64'(credit_ret), 64'h0);

      // Overflow with ready low, then drain in order.
      do_reset("t2_reset");
      for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0, -1, "t2_fill");
      chk("t2_count", 64'(count), 64'd4);
      chk("t2_overflow", 64'(err_overflow), 64'h1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         idle(1, 1'b1, "t2_drain");
         if (credit_ret) pulses++;
      end
      chk("t2_pulses", 64'(pulses), 64'd4);

      // sof arriving on the third beat restarts the word.
      do_reset("t3_reset");
      w = 64'hdeadbeefcafef00d;
      cycle(1'b1, 1'b1, beat_of(w, 0), ^beat_of(w, 0), 1'b0, "t3_a0");
      cycle(1'b1, 1'b0, beat_of(w, 1), ^beat_of(w, 1), 1'b0, "t3_a1");
      send_word(64'h1122334455667788, 1'b0, 1'b0, -1, "t3_b");
      chk("t3_framing", 64'(err_framing), 64'h1);
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_word", data_out, 64'h1122334455667788);

      // Full FIFO, last beat coincides with a pop.
      do_reset("t4_reset");
      for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0, -1, "t4_fill");
      send_word(64'h0123456789abcdef, 1'b0, 1'b1, -1, "t4_edge");
      chk("t4_count", 64'(count), 64'd4);
      chk("t4_overflow", 64'(err_overflow), 64'h0);
      idle(5, 1'b1, "t4_drain");

      // Reset in the middle of a word.
      do_reset("t5_reset");
      cycle(1'b1, 1'b1, 16'haa55, ^16'haa55, 1'b0, "t5_b0");
      cycle(1'b1, 1'b0, 16'h1234, ^16'h1234, 1'b0, "t5_b1");
      do_reset("t5_midreset");
      chk("t5_credit_zero", 64'(credit_ret), 64'h0);
      send_word(64'hfedcba9876543210, 1'b0, 1'b0, -1, "t5_word");
      chk("t5_count", 64'(count), 64'd1);

`ifdef LINK_PARITY_EN
      // Bad parity on beat 1 drops that word only.
      do_reset("t6_reset");
      send_word(64'h5555aaaa3333cccc, 1'b0, 1'b0, 1, "t6_bad");
      chk("t6_parity", 64'(err_parity), 64'h1);
      chk("t6_count", 64'(count), 64'd0);
      idle(2, 1'b1, "t6_nocredit");
      send_word(64'h0f0f0f0ff0f0f0f0, 1'b1, 1'b1, -1, "t6_good");
      chk("t6_word", data_out, 64'h0f0f0f0ff0f0f0f0);
`endif

      // Random beat stream with gaps, random ready and occasional sof corruption.
      do_reset("rnd_reset");
      pos = 0;
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 3) != 0);
         s = (pos == 0);
         if ($urandom_range(0, 24) == 0) s = !s;
         if (v) pos = s ? 1 : ((pos + 1) % 4);
         d = 16'($urandom);
         cycle(v, s, d, (^d) ^ ($urandom_range(0, 30) == 0), $urandom_range(0, 2) != 0, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
